// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO responder: frame field widths, opcodes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdio_pkg;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // One state per management-frame field; every transition happens on an MDC rise
  typedef enum logic [2:0] {
    PRE,
    ST1,
    OP,
    PHYAD,
    REGAD,
    TA1,
    TA2,
    DATA
  } mdio_state_t;

  // Only read and write are Clause-22 opcodes; 00/11 abandon the frame
  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Brings MDC and MDIO into the clk domain and flags each MDC rising edge as a 1-clk pulse.
// Latency: 2 clk synchronizer; rise is high in the cycle the synced mdc first reads 1.
// Backpressure: none; free-running sampler.
module mdio_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic mdc,
  input  logic mdio_in,
  output logic rise,
  output logic mdio_bit
);

  logic mdc_meta;
  logic mdc_sync;
  logic mdc_prev;
  logic mdio_meta;
  logic mdio_sync;

  // Two-flop synchronizers plus a delayed copy of synced mdc for edge detection.
  // MDIO idles high (pull-up), so its flops reset to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdc_meta  <= 1'b0;
      mdc_sync  <= 1'b0;
      mdc_prev  <= 1'b0;
      mdio_meta <= 1'b1;
      mdio_sync <= 1'b1;
    end else begin
      mdc_meta  <= mdc;
      mdc_sync  <= mdc_meta;
      mdc_prev  <= mdc_sync;
      mdio_meta <= mdio_in;
      mdio_sync <= mdio_meta;
    end
  end

  assign rise     = mdc_sync & ~mdc_prev;
  assign mdio_bit = mdio_sync;

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target: decodes management frames and maps them onto a simple register port.
// Latency: outputs update 1 clk after the synced MDC rise; reg_rdata is captured 1 clk after reg_rd.
// Backpressure: none; the master paces everything via MDC and the register port must keep up.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter int PREAMBLE_MIN = 32,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int TIMEOUT_W    = 13
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PHYAD_W-1:0] phy_addr,
  input  logic               mdc,
  input  logic               mdio_in,
  output logic               mdio_out,
  output logic               mdio_oen,
  output logic [REGAD_W-1:0] reg_addr,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic               reg_wr,
  output logic               reg_rd,
  input  logic [DATA_W-1:0]  reg_rdata,
  output logic               busy
);

  localparam int                   PRE_CNT_W  = 6;
  localparam logic [PRE_CNT_W-1:0] PRE_MIN_C  = PRE_CNT_W'(PREAMBLE_MIN);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_C  = TIMEOUT_W'(IDLE_TIMEOUT);
  localparam logic [3:0]           PHYAD_LAST = 4'(PHYAD_W - 1);
  localparam logic [3:0]           REGAD_LAST = 4'(REGAD_W - 1);
  localparam logic [3:0]           DATA_LAST  = 4'(DATA_W - 1);

  logic rise;
  logic bit_in;

  mdio_state_t          state,     state_nxt;
  logic [PRE_CNT_W-1:0] pre_cnt,   pre_cnt_nxt;
  logic [3:0]           bit_cnt,   bit_cnt_nxt;
  logic [1:0]           op_sr,     op_sr_nxt;
  logic [PHYAD_W-1:0]   addr_sr,   addr_sr_nxt;
  logic                 is_read,   is_read_nxt;
  logic                 match,     match_nxt;
  logic [DATA_W-1:0]    shreg,     shreg_nxt;
  logic                 rd_pend;
  logic                 oen_nxt;
  logic                 out_nxt;
  logic [REGAD_W-1:0]   reg_addr_nxt;
  logic [DATA_W-1:0]    reg_wdata_nxt;
  logic                 reg_wr_nxt;
  logic                 reg_rd_nxt;
  logic                 busy_nxt;

  logic [TIMEOUT_W-1:0] tcnt;
  logic                 timeout_hit;

  logic [1:0]           op_word;
  logic [PHYAD_W-1:0]   addr_word;
  logic [DATA_W-1:0]    data_word;

  mdio_sync_edge u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .mdc      (mdc),
    .mdio_in  (mdio_in),
    .rise     (rise),
    .mdio_bit (bit_in)
  );

  // Field words as they will look once the current bit is shifted in
  assign op_word     = {op_sr[0], bit_in};
  assign addr_word   = {addr_sr[PHYAD_W-2:0], bit_in};
  assign data_word   = {shreg[DATA_W-2:0], bit_in};
  assign timeout_hit = (tcnt == TIMEOUT_C);

  // Idle watchdog: clk cycles since the last MDC rise, saturating at the limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (rise) begin
      tcnt <= '0;
    end else if (!timeout_hit) begin
      tcnt <= tcnt + TIMEOUT_W'(1);
    end
  end

  // Frame decoder: next state, shift registers and next values of all registered outputs
  always_comb begin
    state_nxt     = state;
    pre_cnt_nxt   = pre_cnt;
    bit_cnt_nxt   = bit_cnt;
    op_sr_nxt     = op_sr;
    addr_sr_nxt   = addr_sr;
    is_read_nxt   = is_read;
    match_nxt     = match;
    shreg_nxt     = shreg;
    oen_nxt       = mdio_oen;
    out_nxt       = mdio_out;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    reg_wr_nxt    = 1'b0;
    reg_rd_nxt    = 1'b0;
    busy_nxt      = busy;

    // Read data arrives one cycle after the strobe; TA is far enough away that no rise collides
    if (rd_pend) begin
      shreg_nxt = reg_rdata;
    end

    if (timeout_hit && (state != PRE)) begin
      // Master went quiet mid-frame: drop everything, never commit a partial write
      state_nxt   = PRE;
      pre_cnt_nxt = '0;
      busy_nxt    = 1'b0;
      oen_nxt     = 1'b1;
      out_nxt     = 1'b1;
    end else if (rise) begin
      unique case (state)
        PRE: begin
          if (bit_in) begin
            if (pre_cnt < PRE_MIN_C) begin
              pre_cnt_nxt = pre_cnt + PRE_CNT_W'(1);
            end
          end else if (pre_cnt >= PRE_MIN_C) begin
            state_nxt   = ST1;
            pre_cnt_nxt = '0;
            busy_nxt    = 1'b1;
          end else begin
            pre_cnt_nxt = '0;
          end
        end

        ST1: begin
          if (bit_in) begin
            state_nxt   = OP;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt   = PRE;
            pre_cnt_nxt = '0;
            busy_nxt    = 1'b0;
          end
        end

        OP: begin
          op_sr_nxt = op_word;
          if (bit_cnt == 4'd0) begin
            bit_cnt_nxt = 4'd1;
          end else if (op_valid(op_word)) begin
            state_nxt   = PHYAD;
            bit_cnt_nxt = '0;
            is_read_nxt = (op_word == OP_READ);
          end else begin
            state_nxt   = PRE;
            pre_cnt_nxt = '0;
            busy_nxt    = 1'b0;
          end
        end

        PHYAD: begin
          addr_sr_nxt = addr_word;
          if (bit_cnt == PHYAD_LAST) begin
            state_nxt   = REGAD;
            bit_cnt_nxt = '0;
            match_nxt   = (addr_word == phy_addr);
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end

        REGAD: begin
          addr_sr_nxt = addr_word;
          if (bit_cnt == REGAD_LAST) begin
            state_nxt    = TA1;
            bit_cnt_nxt  = '0;
            reg_addr_nxt = addr_word;
            reg_rd_nxt   = is_read & match;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end

        TA1: begin
          // Start driving the TA2 zero so it is settled before the next rise
          state_nxt = TA2;
          if (is_read && match) begin
            oen_nxt = 1'b0;
            out_nxt = 1'b0;
          end
        end

        TA2: begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          if (is_read && match) begin
            out_nxt = shreg[DATA_W-1];
          end
          shreg_nxt = data_word;
        end

        DATA: begin
          // Writes shift in the sampled bit; reads shift out MSB-first (the shifted-in bit is unused)
          shreg_nxt = data_word;
          if (bit_cnt == DATA_LAST) begin
            state_nxt   = PRE;
            pre_cnt_nxt = '0;
            busy_nxt    = 1'b0;
            oen_nxt     = 1'b1;
            out_nxt     = 1'b1;
            if (!is_read && match) begin
              reg_wdata_nxt = data_word;
              reg_wr_nxt    = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (is_read && match) begin
              out_nxt = shreg[DATA_W-1];
            end
          end
        end

        default: begin
          state_nxt   = PRE;
          pre_cnt_nxt = '0;
          busy_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset leaves the bus released and the decoder hunting for preamble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PRE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      op_sr     <= '0;
      addr_sr   <= '0;
      is_read   <= 1'b0;
      match     <= 1'b0;
      shreg     <= '0;
      rd_pend   <= 1'b0;
      mdio_oen  <= 1'b1;
      mdio_out  <= 1'b1;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre_cnt   <= pre_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      op_sr     <= op_sr_nxt;
      addr_sr   <= addr_sr_nxt;
      is_read   <= is_read_nxt;
      match     <= match_nxt;
      shreg     <= shreg_nxt;
      rd_pend   <= reg_rd;
      mdio_oen  <= oen_nxt;
      mdio_out  <= out_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      reg_wr    <= reg_wr_nxt;
      reg_rd    <= reg_rd_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for the MDIO responder: acts as MDIO master and as the register bank behind the port.
// Latency: MDC period is 16 clk; bus sampled just before each MDC rise.
// Backpressure: none.
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  phy_addr;
  logic        mdc;
  logic        master_bit;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        busy;
  logic        bank_load;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Shared open-drain line: the responder wins when it drives, otherwise the master (1 = released)
  assign mdio_in = mdio_oen ? master_bit : mdio_out;

  mdio_phy_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .phy_addr  (phy_addr),
    .mdc       (mdc),
    .mdio_in   (mdio_in),
    .mdio_out  (mdio_out),
    .mdio_oen  (mdio_oen),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  function automatic logic [15:0] init_val(input int i);
    return (i == 2) ? 16'h0141 : 16'(i * 16'h0925 + 16'h1200);
  endfunction

  // Register bank behind the port: synchronous read, one-cycle latency
  logic [15:0] bank [32];
  always @(posedge clk) begin
    if (bank_load) begin
      for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
      reg_rdata <= 16'h0;
    end else begin
      if (reg_wr) bank[reg_addr] <= reg_wdata;
      if (reg_rd) reg_rdata <= bank[reg_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Port monitor, sampled on the falling edge
  int          wr_count = 0, rd_count = 0, both_cnt = 0, oen_lo_cyc = 0, busy_hi_cyc = 0;
  int          wr_cyc = 0;
  logic [4:0]  wr_addr_s;
  logic [15:0] wr_data_s;
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_count++;
      wr_cyc    = cyc;
      wr_addr_s = reg_addr;
      wr_data_s = reg_wdata;
    end
    if (reg_rd) rd_count++;
    if (reg_wr && reg_rd) both_cnt++;
    if (!mdio_oen) oen_lo_cyc++;
    if (busy) busy_hi_cyc++;
  end

  // Reference model state
  logic [15:0] model_mem [32];
  int          run = 0;  // consecutive '1's the responder has seen while hunting for preamble

  logic frame_q [$];
  logic s_line  [$];
  logic s_oen   [$];
  logic s_busy  [$];
  int   rise_cyc = 0;

  task automatic send_bit(input logic b);
    @(negedge clk);
    mdc        = 1'b0;
    master_bit = b;
    repeat (7) @(negedge clk);
    s_line.push_back(mdio_in);
    s_oen.push_back(mdio_oen);
    s_busy.push_back(busy);
    mdc      = 1'b1;
    rise_cyc = cyc;
    repeat (8) @(negedge clk);
  endtask

  task automatic build_frame(input int pre_len, input logic [1:0] op, input logic [4:0] pa,
                             input logic [4:0] ra, input logic [15:0] wd);
    logic rd;
    rd = (op == 2'b10);
    frame_q.delete();
    for (int i = 0; i < pre_len; i++) frame_q.push_back(1'b1);
    frame_q.push_back(1'b0);
    frame_q.push_back(1'b1);
    frame_q.push_back(op[1]);
    frame_q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) frame_q.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) frame_q.push_back(ra[i]);
    frame_q.push_back(1'b1);
    frame_q.push_back(rd ? 1'b1 : 1'b0);
    for (int i = 15; i >= 0; i--) frame_q.push_back(rd ? 1'b1 : wd[i]);
  endtask

  task automatic send_frame(input int n);
    s_line.delete();
    s_oen.delete();
    s_busy.delete();
    for (int i = 0; i < n; i++) send_bit(frame_q[i]);
    master_bit = 1'b1;
  endtask

  function automatic int oen_lo(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (s_oen[i] !== 1'b1) n++;
    return n;
  endfunction

  function automatic int busy_lo(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (s_busy[i] !== 1'b1) n++;
    return n;
  endfunction

  function automatic logic [15:0] line_data(input int base);
    logic [15:0] d = 16'h0;
    for (int k = 0; k < 16; k++) d = {d[14:0], s_line[base + 16 + k]};
    return d;
  endfunction

  function automatic int trailing_ones();
    int n = 0;
    for (int i = frame_q.size() - 1; i >= 0 && frame_q[i] === 1'b1; i--) n++;
    return n;
  endfunction

  task automatic test_reset;
    total++; if (mdio_oen !== 1'b1) begin bad++; $display("FAIL reset_oen: got %b want 1", mdio_oen); end
    total++; if (mdio_out !== 1'b1) begin bad++; $display("FAIL reset_out: got %b want 1", mdio_out); end
    total++; if (reg_addr !== 5'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", reg_addr); end
    total++; if (reg_wdata !== 16'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", reg_wdata); end
    total++; if ({reg_wr, reg_rd, busy} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {reg_wr, reg_rd, busy}); end
  endtask

  task automatic test_write;
    int wr0, oen0, base;
    phy_addr = 5'h01;
    wr0 = wr_count; oen0 = oen_lo_cyc; base = 32;
    build_frame(32, 2'b01, 5'h01, 5'h04, 16'hA5C3);
    send_frame(frame_q.size());
    total++; if (wr_count - wr0 !== 1) begin bad++; $display("FAIL wr_pulses: got %0d want 1", wr_count - wr0); end
    total++; if (wr_addr_s !== 5'h04) begin bad++; $display("FAIL wr_addr: got %h want 04", wr_addr_s); end
    total++; if (wr_data_s !== 16'hA5C3) begin bad++; $display("FAIL wr_data: got %h want a5c3", wr_data_s); end
    total++; if (wr_cyc - rise_cyc !== 3) begin bad++; $display("FAIL wr_timing: got %0d want 3", wr_cyc - rise_cyc); end
    total++; if (oen_lo_cyc - oen0 !== 0) begin bad++; $display("FAIL wr_oen: got %0d want 0", oen_lo_cyc - oen0); end
    total++; if (busy_lo(base + 1, base + 31) !== 0 || s_busy[base] !== 1'b0) begin
      bad++; $display("FAIL wr_busy_window: got %0d want 0", busy_lo(base + 1, base + 31)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    model_mem[4] = 16'hA5C3;
    run = 0;
  endtask

  task automatic test_read;
    int rd0, base;
    phy_addr = 5'h01;
    rd0 = rd_count; base = 32;
    build_frame(32, 2'b10, 5'h01, 5'h02, 16'h0);
    send_frame(frame_q.size());
    total++; if (s_line[base + 15] !== 1'b0) begin bad++; $display("FAIL rd_ta2: got %b want 0", s_line[base + 15]); end
    total++; if (line_data(base) !== model_mem[2]) begin bad++; $display("FAIL rd_data: got %h want %h", line_data(base), model_mem[2]); end
    total++; if (oen_lo(base + 15, base + 31) !== 17) begin bad++; $display("FAIL rd_drive_bits: got %0d want 17", oen_lo(base + 15, base + 31)); end
    total++; if (oen_lo(0, base + 14) !== 0) begin bad++; $display("FAIL rd_drive_early: got %0d want 0", oen_lo(0, base + 14)); end
    total++; if (rd_count - rd0 !== 1) begin bad++; $display("FAIL rd_pulses: got %0d want 1", rd_count - rd0); end
    total++; if (mdio_oen !== 1'b1) begin bad++; $display("FAIL rd_release: got %b want 1", mdio_oen); end
    run = 0;
  endtask

  task automatic test_mismatch;
    int rd0, wr0, oen0, base;
    rd0 = rd_count; wr0 = wr_count; oen0 = oen_lo_cyc; base = 32;
    build_frame(32, 2'b10, 5'h1F, 5'h02, 16'h0);
    send_frame(frame_q.size());
    total++; if ((rd_count - rd0) + (wr_count - wr0) !== 0) begin bad++; $display("FAIL mis_strobes: got %0d want 0", (rd_count - rd0) + (wr_count - wr0)); end
    total++; if (oen_lo_cyc - oen0 !== 0) begin bad++; $display("FAIL mis_oen: got %0d want 0", oen_lo_cyc - oen0); end
    total++; if (busy_lo(base + 1, base + 31) !== 0) begin bad++; $display("FAIL mis_busy: got %0d want 0", busy_lo(base + 1, base + 31)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mis_busy_end: got %b want 0", busy); end
    run = 0;
  endtask

  task automatic test_short_preamble;
    int wr0, b0;
    wr0 = wr_count; b0 = busy_hi_cyc;
    build_frame(20, 2'b01, 5'h01, 5'h07, 16'h1234);
    send_frame(frame_q.size());
    total++; if (wr_count - wr0 !== 0) begin bad++; $display("FAIL short_wr: got %0d want 0", wr_count - wr0); end
    total++; if (busy_hi_cyc - b0 !== 0) begin bad++; $display("FAIL short_busy: got %0d want 0", busy_hi_cyc - b0); end
    run = trailing_ones();
    wr0 = wr_count;
    build_frame(32, 2'b01, 5'h01, 5'h07, 16'hBEEF);
    send_frame(frame_q.size());
    total++; if (wr_count - wr0 !== 1 || wr_data_s !== 16'hBEEF || wr_addr_s !== 5'h07) begin
      bad++; $display("FAIL full_pre_wr: got n=%0d a=%h d=%h want n=1 a=07 d=beef", wr_count - wr0, wr_addr_s, wr_data_s); end
    model_mem[7] = 16'hBEEF;
    run = 0;
  endtask

  task automatic test_bad_opcode;
    build_frame(32, 2'b11, 5'h01, 5'h03, 16'h0);
    send_frame(32 + 4);
    total++; if (s_busy[32 + 2] !== 1'b1) begin bad++; $display("FAIL badop_st_busy: got %b want 1", s_busy[32 + 2]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL badop_busy: got %b want 0", busy); end
    run = 0;
  endtask

  task automatic test_stall;
    int wr0;
    logic [15:0] wd;
    wr0 = wr_count;
    wd = 16'($urandom);
    build_frame(32, 2'b01, 5'h01, 5'h09, wd);
    send_frame(32 + 16 + 8);
    repeat (4000) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_early: got %b want 1", busy); end
    repeat (200) @(negedge clk);
    total++; if (busy !== 1'b0 || mdio_oen !== 1'b1) begin bad++; $display("FAIL stall_abort: got busy=%b oen=%b want 0 1", busy, mdio_oen); end
    total++; if (wr_count - wr0 !== 0) begin bad++; $display("FAIL stall_wr: got %0d want 0", wr_count - wr0); end
    run = 0;
    build_frame(32, 2'b01, 5'h01, 5'h09, wd);
    send_frame(frame_q.size());
    total++; if (wr_count - wr0 !== 1 || wr_data_s !== wd) begin bad++; $display("FAIL stall_next: got n=%0d d=%h want n=1 d=%h", wr_count - wr0, wr_data_s, wd); end
    model_mem[9] = wd;
  endtask

  task automatic test_reset_mid_read;
    int rd0;
    build_frame(32, 2'b10, 5'h01, 5'h05, 16'h0);
    send_frame(32 + 16 + 8);
    total++; if (mdio_oen !== 1'b0 || mdio_out !== model_mem[5][7]) begin
      bad++; $display("FAIL mid_d7: got oen=%b out=%b want 0 %b", mdio_oen, mdio_out, model_mem[5][7]); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (mdio_oen !== 1'b1 || mdio_out !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got oen=%b out=%b busy=%b want 1 1 0", mdio_oen, mdio_out, busy); end
    mdc = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run = 0;
    rd0 = rd_count;
    build_frame(32, 2'b10, 5'h01, 5'h05, 16'h0);
    send_frame(frame_q.size());
    total++; if (line_data(32) !== model_mem[5] || s_line[32 + 15] !== 1'b0 || rd_count - rd0 !== 1) begin
      bad++; $display("FAIL post_reset_rd: got d=%h ta=%b n=%0d want d=%h ta=0 n=1", line_data(32), s_line[47], rd_count - rd0, model_mem[5]); end
  endtask

  task automatic test_back_to_back;
    int pre_tab [5] = '{24, 28, 32, 33, 40};
    for (int n = 0; n < 12; n++) begin
      int pre_len, wr0, rd0, oen0, b0;
      logic is_rd, match, acc;
      logic [4:0] pa, ra;
      logic [15:0] wd;
      pre_len  = pre_tab[$urandom_range(4, 0)];
      is_rd    = 1'($urandom_range(1, 0));
      match    = ($urandom_range(3, 0) != 0);
      phy_addr = 5'($urandom);
      pa       = match ? phy_addr : (phy_addr ^ 5'($urandom_range(31, 1)));
      ra       = 5'($urandom);
      wd       = 16'($urandom);
      acc      = (run + pre_len >= 32);
      wr0 = wr_count; rd0 = rd_count; oen0 = oen_lo_cyc; b0 = busy_hi_cyc;
      build_frame(pre_len, is_rd ? 2'b10 : 2'b01, pa, ra, wd);
      send_frame(frame_q.size());
      if (acc && match && !is_rd) begin
        total++; if (wr_count - wr0 !== 1 || wr_addr_s !== ra || wr_data_s !== wd) begin
          bad++; $display("FAIL b2b_wr[%0d]: got n=%0d a=%h d=%h want n=1 a=%h d=%h", n, wr_count - wr0, wr_addr_s, wr_data_s, ra, wd); end
        model_mem[ra] = wd;
      end else if (acc && match && is_rd) begin
        total++; if (rd_count - rd0 !== 1 || line_data(pre_len) !== model_mem[ra] || oen_lo(pre_len + 15, pre_len + 31) !== 17) begin
          bad++; $display("FAIL b2b_rd[%0d]: got n=%0d d=%h want n=1 d=%h", n, rd_count - rd0, line_data(pre_len), model_mem[ra]); end
      end else begin
        total++; if (wr_count - wr0 !== 0 || rd_count - rd0 !== 0 || oen_lo_cyc - oen0 !== 0) begin
          bad++; $display("FAIL b2b_quiet[%0d]: got wr=%0d rd=%0d oen=%0d want 0 0 0", n, wr_count - wr0, rd_count - rd0, oen_lo_cyc - oen0); end
      end
      total++; if (acc ? (s_busy[pre_len + 1] !== 1'b1) : (busy_hi_cyc - b0 !== 0)) begin
        bad++; $display("FAIL b2b_busy[%0d]: got acc_busy=%b hi_cyc=%0d want acc=%b", n, s_busy[pre_len + 1], busy_hi_cyc - b0, acc); end
      run = acc ? 0 : trailing_ones();
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    mdc        = 1'b0;
    master_bit = 1'b1;
    phy_addr   = 5'h01;
    bank_load  = 1'b1;
    for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
    repeat (2) @(negedge clk);
    bank_load = 1'b0;
    test_reset;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    test_write;
    test_read;
    test_mismatch;
    test_short_preamble;
    test_bad_opcode;
    test_stall;
    test_reset_mid_read;
    test_back_to_back;
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL wr_rd_overlap: got %0d want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- Clause-22 MDIO target (PHY-side responder) that answers the management frames issued by the TSE MAC MDIO master on the board.
- Used as an on-FPGA management target for soft PHY/PCS register banks, and as the bench-side PHY model for the Ethernet subsystem.
- Oversamples MDC/MDIO on the system clock.
- Exposes a simple register-access port: one-cycle write strobe, fixed one-cycle read latency.

Parameters:
- PREAMBLE_MIN, 32, consecutive '1' bits required before a start pattern is accepted (1..32).
- IDLE_TIMEOUT, 4096, clk cycles without an MDC rising edge before any frame in progress is abandoned.
- TIMEOUT_W, 13, width of the idle-timeout counter; must hold IDLE_TIMEOUT.

Ports:
- clk  in  1  system clock, at least 8x the MDC frequency.
- reset_n  in  1  asynchronous, active-low reset.
- phy_addr  in  5  this target's PHYAD; quasi-static.
- mdc  in  1  management clock from the master; asynchronous to clk.
- mdio_in  in  1  MDIO pad input.
- mdio_out  out  1  MDIO drive value.
- mdio_oen  out  1  active-low output enable; 0 = drive mdio_out, 1 = release.
- reg_addr  out  5  REGAD of the current frame.
- reg_wdata  out  16  write data; valid while reg_wr=1.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  16  read data, sampled exactly 1 clk after reg_rd.
- busy  out  1  high from an accepted ST until frame end or abort.

Behaviour:
- Reset values:
  - mdio_oen=1, mdio_out=1.
  - reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0.
  - FSM in PRE; preamble count 0; timeout count 0.
- Sampling:
  - mdc and mdio_in each pass through a 2-flop synchronizer.
  - An MDC rising edge is detected on the synced mdc (1 clk pulse, "rise").
  - Every frame bit is the synced mdio value in the rise cycle.
- Drive timing: mdio_oen/mdio_out update in the clk cycle after a rise, so each driven bit is stable before the next MDC rising edge.
- FSM, advancing only on rise:
  - PRE: bit 1 increments the preamble count (saturates at PREAMBLE_MIN). Bit 0 with count >= PREAMBLE_MIN -> ST1, busy=1. Bit 0 with count < PREAMBLE_MIN -> count=0, stay in PRE.
  - ST1: bit 1 -> OP. Bit 0 -> PRE with count 0.
  - OP: captures 2 bits. 10 = read, 01 = write. 00 or 11 -> PRE, count 0, busy=0.
  - PHYAD: 5 bits, MSB first. Match = (captured == phy_addr).
  - REGAD: 5 bits, MSB first; reg_addr updates when the 5th bit is sampled. On a read with match, reg_rd pulses in that same update cycle.
  - TA1: read with match -> stays released. Write -> sampled value ignored.
  - TA2: read with match -> drive 0 (mdio_oen=0, mdio_out=0) for this bit. Write -> ignored; TA is not checked.
  - DATA: 16 bits.
    - Read with match: shift register loaded with reg_rdata 1 clk after reg_rd; drives D15..D0, one bit per rise.
    - Write: shifts in D15..D0.
    - After the 16th rise, go to PRE with count 0 and busy=0.
    - Read: release (mdio_oen=1, mdio_out=1) in the clk after the 16th rise.
    - Write with match: reg_wdata loaded and reg_wr=1 for exactly 1 clk, in the clk after the 16th rise.
  - No match: the frame is tracked to the end with the bus never driven, no strobes, busy still asserted.
- Preamble suppression: back-to-back frames are not accepted unless PREAMBLE_MIN '1' bits precede ST.
- Idle timeout: counts clk cycles since the last rise; cleared by each rise. On reaching IDLE_TIMEOUT outside PRE:
  - FSM -> PRE, count 0, busy=0, bus released.
  - No reg_wr is issued for a partial write.
- reset_n asserted mid-frame: all outputs take reset values immediately (asynchronous).
- reg_wr and reg_rd are never high together; each is at most one pulse per frame.

Decomposition:
- Shared package mdio_pkg:
  - FSM state enum (PRE, ST1, OP, PHYAD, REGAD, TA1, TA2, DATA).
  - Opcode constants OP_READ=2'b10, OP_WRITE=2'b01.
  - Field widths PHYAD_W=5, REGAD_W=5, DATA_W=16.
- Sub-module mdio_sync_edge: 2-flop synchronizer for mdc and mdio_in plus rising-edge pulse generation. Instantiated once.

Test Plan:
- Write: phy_addr=5'h01; frame 32x'1', 01, 01, 00001, 00100, TA 10, data 16'hA5C3 -> reg_wr single pulse with reg_addr=5'h04, reg_wdata=16'hA5C3 in the clk after the 16th rise; mdio_oen stays 1 throughout.
- Read: frame to PHYAD 5'h01, REGAD 5'h02, with the bench returning reg_rdata=16'h0141 1 clk after reg_rd -> mdio_oen=0 from TA2 through D0; master samples 0 then 0x0141; mdio_oen=1 after the last rise.
- Address mismatch: read to PHYAD 5'h1F with phy_addr=5'h01 -> no reg_rd/reg_wr; mdio_oen=1 for the whole frame; busy high ST..D0.
- Short preamble: 20x'1' then a valid write frame -> ignored, no reg_wr. Then 32x'1' plus a valid write -> accepted.
- Bad opcode / MDC stall:
  - OP=11 -> return to PRE, busy=0.
  - Write frame halted after 8 data bits with MDC held for 4096 clk -> busy=0, no reg_wr; next full frame accepted.
- Reset mid-read: assert reset_n=0 during DATA bit 7 -> mdio_oen=1 immediately; after release, a fresh read frame completes correctly.
